// File: rtl/sequence_pattern_tx_pkg.sv
// Shared definitions for the serial sequence path: transmitter FSM states and
// the reference pattern that the detector blocks also match against.
package sequence_pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_t;

   localparam int               DEFAULT_PATTERN_W = 5;
   localparam logic [4:0]       DEFAULT_PATTERN   = 5'b10011;

endpackage

// File: rtl/sequence_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first COUNT times, optionally
// separated by GAP idle cycles, with framing, busy and completion strobes.
module sequence_pattern_tx
   import sequence_pattern_tx_pkg::*;
#(
   parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
   parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
   parameter int                   GAP       = 0,
   parameter int                   CNT_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [CNT_W-1:0] COUNT,
   input  logic             ABORT,
   output logic             O,
   output logic             VALID,
   output logic             FRAME,
   output logic             BUSY,
   output logic             DONE
);

   localparam int BIT_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PATTERN_W - 1);
   localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_t        state, state_n;
   logic [BIT_W-1:0] bit_idx, bit_n;
   logic [GAP_W-1:0] gap_cnt, gap_n;
   logic [CNT_W-1:0] rep_cnt, rep_n;
   logic             done_n;

   // The repetition counter holds the repetitions still owed, including the
   // one currently on the wire, so COUNT at full scale never wraps.
   always_comb begin
      state_n = state;
      bit_n   = bit_idx;
      gap_n   = gap_cnt;
      rep_n   = rep_cnt;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               if (COUNT != '0) begin
                  state_n = ST_SEND;
                  bit_n   = BIT_TOP;
                  rep_n   = COUNT;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (ABORT) begin
               state_n = ST_IDLE;
            end else if (bit_idx != '0) begin
               bit_n = bit_idx - BIT_W'(1);
            end else if (rep_cnt > CNT_W'(1)) begin
               rep_n = rep_cnt - CNT_W'(1);
               if (GAP > 0) begin
                  state_n = ST_GAP;
                  gap_n   = GAP_TOP;
               end else begin
                  bit_n = BIT_TOP;
               end
            end else begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end
         end
         ST_GAP: begin
            if (ABORT) begin
               state_n = ST_IDLE;
            end else if (gap_cnt != '0) begin
               gap_n = gap_cnt - GAP_W'(1);
            end else begin
               state_n = ST_SEND;
               bit_n   = BIT_TOP;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         bit_idx <= '0;
         gap_cnt <= '0;
         rep_cnt <= '0;
         O       <= 1'b0;
         VALID   <= 1'b0;
         FRAME   <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_idx <= bit_n;
         gap_cnt <= gap_n;
         rep_cnt <= rep_n;
         O       <= (state_n == ST_SEND) && PATTERN[bit_n];
         VALID   <= (state_n == ST_SEND);
         FRAME   <= (state_n == ST_SEND) && (bit_n == BIT_TOP);
         BUSY    <= (state_n != ST_IDLE);
         DONE    <= done_n;
      end
   end

endmodule

// File: tb/tb_sequence_pattern_tx.sv
// Bench for sequence_pattern_tx: a vector table for a single-shot run, then
// scoreboarded sequences on a GAP=0 and a GAP=2 instance.
module tb_sequence_pattern_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [7:0] COUNT = 8'd0;

   logic o0, v0, f0, b0, d0;
   logic o2, v2, f2, b2, d2;
   logic [4:0] out0, out2;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   typedef struct {
      logic       start;
      logic [7:0] count;
      logic       abort;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[10];

   always #5 CLK = ~CLK;

   assign out0 = {o0, v0, f0, b0, d0};
   assign out2 = {o2, v2, f2, b2, d2};

   sequence_pattern_tx #(.GAP(0)) dut0 (
      .CLK(CLK), .RST(RST), .START(START), .COUNT(COUNT), .ABORT(ABORT),
      .O(o0), .VALID(v0), .FRAME(f0), .BUSY(b0), .DONE(d0)
   );

   sequence_pattern_tx #(.GAP(2)) dut2 (
      .CLK(CLK), .RST(RST), .START(START), .COUNT(COUNT), .ABORT(ABORT),
      .O(o2), .VALID(v2), .FRAME(f2), .BUSY(b2), .DONE(d2)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic [7:0] count, input logic abort);
      START = start;
      COUNT = count;
      ABORT = abort;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%b want=%b (o,valid,frame,busy,done)", name, act, exp);
      end
   endtask

   // Expected {o,valid,frame,busy,done} in cycle n of a run started at edge 0,
   // from the span/period timing formulas; cut>=0 silences everything after it.
   function automatic logic [4:0] model(int n, int cnt, int g, int cut);
      logic [4:0] pat = 5'b10011;
      int span;
      int p;
      if (cut >= 0 && n > cut) return 5'b00000;
      span = (cnt == 0) ? 0 : cnt * 5 + (cnt - 1) * g;
      if (n <= span) begin
         p = (n - 1) % (5 + g);
         if (p < 5) return {pat[4 - p], 1'b1, (p == 0), 1'b1, 1'b0};
         return 5'b00010;
      end
      if (n == span + 1) return 5'b00001;
      return 5'b00000;
   endfunction

   task automatic doReset(input string name);
      applyStimulus(1'b0, 8'd0, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checkOutput({name, " dut0"}, out0, 5'b00000);
      checkOutput({name, " dut2"}, out2, 5'b00000);
   endtask

   task automatic runSeq(input string name, input int cnt, input bit use_gap, input int cut,
                         input bit cut_rst, input int tail, input bit poke);
      int g;
      int span;
      int ncyc;
      logic [4:0] exp;
      g    = use_gap ? 2 : 0;
      span = (cnt == 0) ? 0 : cnt * 5 + (cnt - 1) * g;
      ncyc = (cut >= 0) ? cut + 1 + tail : span + 1 + tail;
      for (int n = 1; n <= ncyc; n++) exp_q.push_back(model(n, cnt, g, cut));
      for (int e = 0; e < ncyc; e++) begin
         applyStimulus((e == 0) || (poke && e <= span && (e % 2 == 1)),
                       (e == 0) ? 8'(cnt) : 8'd7,
                       !cut_rst && (e == cut));
         RST = cut_rst && (e == cut);
         tick();
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard empty at cycle %0d", name, e + 1);
         end else begin
            exp = exp_q.pop_front();
            checkOutput($sformatf("%s c%0d", name, e + 1), use_gap ? out2 : out0, exp);
         end
      end
      RST = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'd1, 1'b0, 5'b11110};
      vecs[1] = '{1'b0, 8'd0, 1'b0, 5'b01010};
      vecs[2] = '{1'b0, 8'd0, 1'b0, 5'b01010};
      vecs[3] = '{1'b0, 8'd0, 1'b0, 5'b11010};
      vecs[4] = '{1'b0, 8'd0, 1'b0, 5'b11010};
      vecs[5] = '{1'b0, 8'd0, 1'b0, 5'b00001};
      vecs[6] = '{1'b0, 8'd0, 1'b0, 5'b00000};
      vecs[7] = '{1'b0, 8'd0, 1'b1, 5'b00000};
      vecs[8] = '{1'b1, 8'd0, 1'b0, 5'b00001};
      vecs[9] = '{1'b0, 8'd0, 1'b0, 5'b00000};

      tick();
      doReset("reset");

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].start, vecs[i].count, vecs[i].abort);
         tick();
         checkOutput($sformatf("table row%0d", i), out0, vecs[i].exp);
      end
      applyStimulus(1'b0, 8'd0, 1'b0);

      runSeq("gap0 x3", 3, 1'b0, -1, 1'b0, 1, 1'b0);
      doReset("pre-gap reset");
      runSeq("gap2 x2", 2, 1'b1, -1, 1'b0, 1, 1'b0);
      doReset("pre-abort reset");
      runSeq("abort", 1, 1'b0, 3, 1'b0, 0, 1'b0);
      runSeq("restart", 1, 1'b0, -1, 1'b0, 0, 1'b0);
      runSeq("back2back", 2, 1'b0, -1, 1'b0, 1, 1'b0);
      runSeq("count0", 0, 1'b0, -1, 1'b0, 1, 1'b0);
      runSeq("busy start", 2, 1'b0, -1, 1'b0, 2, 1'b1);
      runSeq("reset mid", 4, 1'b0, 3, 1'b1, 2, 1'b0);
      runSeq("count255", 255, 1'b0, -1, 1'b0, 1, 1'b0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard leftover got=%0d want=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
